// File: rtl/operand_sel_pipe_if.sv
// Producer/consumer bundle for the operand select stage: sources, select and
// input handshake in; selected operand, output handshake and error status out.
interface operand_sel_pipe_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_IN      = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic [N_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]      in_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  sel_err;
   logic [ERR_CNT_W-1:0]  err_cnt;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, sel_err, err_cnt
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, sel_err, err_cnt
   );
endinterface

// File: rtl/operand_sel_pipe.sv
// Registered N-way operand select with a 2-entry skid buffer; illegal selects
// are consumed, flagged for one cycle and counted (saturating).
module operand_sel_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_IN      = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input logic              clk_i,
   input logic              rst_ni,
   operand_sel_pipe_if.slave bus
);
   localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      main_q, main_d;
   logic [WIDTH-1:0]      skid_q, skid_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  out_valid_q;
   logic                  in_ready_q;
   logic                  sel_err_q;
   logic [WIDTH-1:0]      mux_val;
   logic                  sel_legal;
   logic                  in_fire;
   logic                  out_fire;
   logic                  accept;
   logic                  illegal;

   // Out-of-range selects leave mux_val at zero; they are never enqueued anyway.
   always_comb begin
      mux_val = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (bus.in_sel == SEL_W'(i)) begin
            mux_val = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign sel_legal = ({1'b0, bus.in_sel} < (SEL_W+1)'(N_IN));
   assign in_fire   = bus.in_valid & in_ready_q;
   assign out_fire  = out_valid_q & bus.out_ready;
   assign accept    = in_fire & ~bus.flush & sel_legal;
   assign illegal   = in_fire & ~bus.flush & ~sel_legal;

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      err_cnt_d = err_cnt_q;

      if (illegal && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = mux_val;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && out_fire) begin
               main_d = mux_val;
            end else if (accept) begin
               skid_d  = mux_val;
               state_d = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush wins over every transition; the error count survives it.
      if (bus.flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         err_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         err_cnt_q   <= err_cnt_d;
         out_valid_q <= (state_d != ST_EMPTY);
         in_ready_q  <= (state_d != ST_TWO);
         sel_err_q   <= illegal;
      end
   end

   assign bus.out_data  = main_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: directed scenarios on a 4-channel and a 3-channel
// instance, then a randomized run against a 2-deep FIFO reference model.
module tb_operand_sel_pipe;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   operand_sel_pipe_if #(.WIDTH(W), .N_IN(4), .ERR_CNT_W(8)) ia ();
   operand_sel_pipe_if #(.WIDTH(W), .N_IN(3), .ERR_CNT_W(2)) ib ();

   operand_sel_pipe #(.WIDTH(W), .N_IN(4), .ERR_CNT_W(8)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(ia.slave));
   operand_sel_pipe #(.WIDTH(W), .N_IN(3), .ERR_CNT_W(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(ib.slave));

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", ia.out_valid); end
      total++; if (ia.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got %h want 0", ia.out_data); end
      total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", ia.in_ready); end
      total++; if (ia.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got %0d want 0", ia.err_cnt); end
      total++; if (ia.sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err got %b want 0", ia.sel_err); end
      total++; if (ib.in_ready !== 1'b0) begin bad++; $display("FAIL rst_b_in_ready got %b want 0", ib.in_ready); end
      rst_n = 1'b1;
      step();
      total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got %b want 1", ia.in_ready); end
      total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got %b want 0", ia.out_valid); end
      total++; if (ib.in_ready !== 1'b1) begin bad++; $display("FAIL rel_b_in_ready got %b want 1", ib.in_ready); end
   endtask

   task automatic test_stream();
      logic [W-1:0] exp [4];
      exp = '{32'h11, 32'h22, 32'h33, 32'h44};
      ia.out_ready = 1'b1;
      ia.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
      for (int k = 0; k < 4; k++) begin
         ia.in_sel   = 2'(k);
         ia.in_valid = 1'b1;
         step();
         total++; if (ia.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got %b want 1", k, ia.out_valid); end
         total++; if (ia.out_data !== exp[k]) begin bad++; $display("FAIL stream_data[%0d] got %h want %h", k, ia.out_data, exp[k]); end
         total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got %b want 1", k, ia.in_ready); end
      end
      ia.in_valid = 1'b0;
      step();
      total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got %b want 0", ia.out_valid); end
      total++; if (ia.out_data !== 32'h44) begin bad++; $display("FAIL stream_drain_hold got %h want 44", ia.out_data); end
   endtask

   task automatic test_backpressure();
      logic [4*W-1:0] d;
      logic [W-1:0]   a, b;
      a = $urandom();
      b = $urandom();
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      d[W +: W] = a;
      ia.out_ready = 1'b0;
      ia.in_data   = d;
      ia.in_sel    = 2'd1;
      ia.in_valid  = 1'b1;
      step();
      total++; if (ia.out_data !== a) begin bad++; $display("FAIL bp_first got %h want %h", ia.out_data, a); end
      total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got %b want 1", ia.in_ready); end
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      d[2*W +: W] = b;
      ia.in_data = d;
      ia.in_sel  = 2'd2;
      step();
      total++; if (ia.out_data !== a) begin bad++; $display("FAIL bp_hold_a got %h want %h", ia.out_data, a); end
      total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %b want 0", ia.in_ready); end
      ia.in_valid = 1'b0;
      ia.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      total++; if (ia.out_data !== a || ia.out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall got %h/%b want %h/1", ia.out_data, ia.out_valid, a); end
      total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got %b want 0", ia.in_ready); end
      ia.out_ready = 1'b1;
      step();
      total++; if (ia.out_data !== b || ia.out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got %h/%b want %h/1", ia.out_data, ia.out_valid, b); end
      total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_again got %b want 1", ia.in_ready); end
      step();
      total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got %b want 0", ia.out_valid); end
   endtask

   task automatic test_illegal();
      ib.out_ready = 1'b1;
      ib.in_data   = {$urandom(), $urandom(), $urandom()};
      ib.in_sel    = 2'b11;
      ib.in_valid  = 1'b1;
      step();
      ib.in_valid = 1'b0;
      total++; if (ib.out_valid !== 1'b0) begin bad++; $display("FAIL ill_no_valid got %b want 0", ib.out_valid); end
      total++; if (ib.sel_err !== 1'b1) begin bad++; $display("FAIL ill_sel_err got %b want 1", ib.sel_err); end
      total++; if (ib.err_cnt !== 2'd1) begin bad++; $display("FAIL ill_err_cnt got %0d want 1", ib.err_cnt); end
      total++; if (ib.in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got %b want 1", ib.in_ready); end
      step();
      total++; if (ib.sel_err !== 1'b0) begin bad++; $display("FAIL ill_pulse_end got %b want 0", ib.sel_err); end
      total++; if (ib.err_cnt !== 2'd1) begin bad++; $display("FAIL ill_cnt_hold got %0d want 1", ib.err_cnt); end
   endtask

   task automatic test_flush();
      ib.out_ready = 1'b0;
      ib.in_data   = {$urandom(), $urandom(), $urandom()};
      ib.in_sel    = 2'd0;
      ib.in_valid  = 1'b1;
      step();
      ib.in_sel = 2'd1;
      step();
      total++; if (ib.in_ready !== 1'b0) begin bad++; $display("FAIL fl_full got %b want 0", ib.in_ready); end
      ib.flush  = 1'b1;
      ib.in_sel = 2'd2;
      step();
      ib.flush    = 1'b0;
      ib.in_valid = 1'b0;
      total++; if (ib.out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got %b want 0", ib.out_valid); end
      total++; if (ib.out_data !== 32'h0) begin bad++; $display("FAIL fl_data got %h want 0", ib.out_data); end
      total++; if (ib.in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got %b want 1", ib.in_ready); end
      total++; if (ib.err_cnt !== 2'd1) begin bad++; $display("FAIL fl_err_keep got %0d want 1", ib.err_cnt); end
      ib.flush    = 1'b1;
      ib.in_sel   = 2'b11;
      ib.in_valid = 1'b1;
      step();
      ib.flush    = 1'b0;
      ib.in_valid = 1'b0;
      total++; if (ib.sel_err !== 1'b0) begin bad++; $display("FAIL fl_drop_sel_err got %b want 0", ib.sel_err); end
      total++; if (ib.err_cnt !== 2'd1) begin bad++; $display("FAIL fl_drop_cnt got %0d want 1", ib.err_cnt); end
      total++; if (ib.out_valid !== 1'b0) begin bad++; $display("FAIL fl_drop_valid got %b want 0", ib.out_valid); end
   endtask

   task automatic test_saturate();
      logic [1:0] exp;
      ib.out_ready = 1'b1;
      ib.in_sel    = 2'b11;
      ib.in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         exp = (k + 2 > 3) ? 2'd3 : 2'(k + 2);
         total++; if (ib.sel_err !== 1'b1) begin bad++; $display("FAIL sat_pulse[%0d] got %b want 1", k, ib.sel_err); end
         total++; if (ib.err_cnt !== exp) begin bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, ib.err_cnt, exp); end
      end
      ib.in_valid = 1'b0;
      step();
      total++; if (ib.err_cnt !== 2'd3) begin bad++; $display("FAIL sat_final got %0d want 3", ib.err_cnt); end
   endtask

   task automatic test_reset_mid();
      ib.out_ready = 1'b0;
      ib.in_data   = {$urandom(), $urandom(), $urandom()};
      ib.in_sel    = 2'd2;
      ib.in_valid  = 1'b1;
      step();
      step();
      ib.in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      total++; if (ib.out_valid !== 1'b0 || ib.out_data !== 32'h0) begin bad++; $display("FAIL rm_out got %b/%h want 0/0", ib.out_valid, ib.out_data); end
      total++; if (ib.in_ready !== 1'b0 || ib.err_cnt !== 2'd0) begin bad++; $display("FAIL rm_ctl got %b/%0d want 0/0", ib.in_ready, ib.err_cnt); end
      rst_n = 1'b1;
      step();
      total++; if (ib.in_ready !== 1'b1 || ib.out_valid !== 1'b0) begin bad++; $display("FAIL rm_release got %b/%b want 1/0", ib.in_ready, ib.out_valid); end
   endtask

   // Reference: a 2-deep FIFO; the stage is ready whenever it holds fewer than two.
   task automatic test_random();
      logic [W-1:0]   q[$];
      logic [W-1:0]   last;
      logic [3*W-1:0] d;
      logic [1:0]     exp_err;
      int             errs;
      int             sel;
      bit             m_ready, m_serr, v, ordy, fl, ifire, ofire;
      last = '0; errs = 0; m_ready = 1'b1; m_serr = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         exp_err = (errs > 3) ? 2'd3 : 2'(errs);
         total++; if (ib.out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid@%0d got %b want %b", cyc, ib.out_valid, q.size() > 0); end
         total++; if (ib.out_data !== last) begin bad++; $display("FAIL rnd_data@%0d got %h want %h", cyc, ib.out_data, last); end
         total++; if (ib.in_ready !== m_ready) begin bad++; $display("FAIL rnd_ready@%0d got %b want %b", cyc, ib.in_ready, m_ready); end
         total++; if (ib.sel_err !== m_serr) begin bad++; $display("FAIL rnd_sel_err@%0d got %b want %b", cyc, ib.sel_err, m_serr); end
         total++; if (ib.err_cnt !== exp_err) begin bad++; $display("FAIL rnd_err_cnt@%0d got %0d want %0d", cyc, ib.err_cnt, exp_err); end

         v    = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 39) == 0);
         sel  = $urandom_range(0, 3);
         d    = {$urandom(), $urandom(), $urandom()};
         ib.in_valid  = v;
         ib.out_ready = ordy;
         ib.flush     = fl;
         ib.in_sel    = 2'(sel);
         ib.in_data   = d;

         ifire = v && m_ready;
         ofire = (q.size() > 0) && ordy;
         m_serr = 1'b0;
         if (fl) begin
            q.delete();
            last = '0;
         end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
               if (sel < 3) q.push_back(d[sel*W +: W]);
               else begin errs++; m_serr = 1'b1; end
            end
         end
         if (q.size() > 0) last = q[0];
         m_ready = (q.size() < 2);
         step();
      end
      ib.in_valid = 1'b0;
      ib.flush    = 1'b0;
   endtask

   initial begin
      ia.in_data = '0; ia.in_sel = '0; ia.in_valid = 1'b0; ia.flush = 1'b0; ia.out_ready = 1'b0;
      ib.in_data = '0; ib.in_sel = '0; ib.in_valid = 1'b0; ib.flush = 1'b0; ib.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_illegal();
      test_flush();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
